mem_access_unit: RTL and testbench

// - Memory stage of the 32-bit core: takes the execute-stage result as a data-memory address.
// - Issues one load or store per request to data memory over a valid/ready handshake.
// - Returns aligned, extended load data as DM, which the writeback select mux chooses against ALU data.
// - Produces the pipeline stall while an access is outstanding.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/load_align.sv | 29 ++
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage.
// Access sizes, FSM states and the alignment check.
package mem_pkg;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } mau_state_t;

    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3)
            SIZE_H, SIZE_HU: mis = off[0];
            SIZE_W:          mis = (off != 2'b00);
            default:         mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of a fetched data word.
// Purely combinational; fed from the captured offset and size.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            SIZE_B:  result = {{24{lane_b[7]}}, lane_b};
            SIZE_BU: result = {24'h0, lane_b};
            SIZE_H:  result = {{16{lane_h[15]}}, lane_h};
            SIZE_HU: result = {16'h0, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: one load/store per request over a valid/ready handshake,
// with aligned load return, stall generation and a BUSY timeout.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] dm_rdata
);

    mau_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        req_d, we_d, stall_d, done_d, err_d;
    logic [31:0] addr_d, wdata_d, dm_d;
    logic [3:0]  be_d;

    logic        op_ok, f3_ok, legal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    load_align u_align (
        .rdata  (mem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .result (ld_data)
    );

    always_comb begin
        op_ok = is_load ^ is_store;
        f3_ok = 1'b0;
        case (funct3)
            SIZE_B, SIZE_H, SIZE_W: f3_ok = 1'b1;
            SIZE_BU, SIZE_HU:       f3_ok = is_load;
            default:                f3_ok = 1'b0;
        endcase
        legal = op_ok && f3_ok && !is_misaligned(funct3, addr[1:0]);
    end

    // Store lane steering: replicate data so any enabled lane sees it.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        case (funct3)
            SIZE_B: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            SIZE_H: begin
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        req_d   = mem_req;
        we_d    = mem_we;
        addr_d  = mem_addr;
        be_d    = mem_be;
        wdata_d = mem_wdata;
        stall_d = stall;
        dm_d    = dm_rdata;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && legal) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    req_d   = 1'b1;
                    stall_d = 1'b1;
                    we_d    = is_store;
                    addr_d  = {addr[31:2], 2'b00};
                    be_d    = is_store ? st_be : 4'b1111;
                    wdata_d = is_store ? st_wdata : 32'h0;
                end else if (req_valid) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    dm_d    = 32'h0;
                end
            end
            BUSY: begin
                // A response on the final allowed cycle still counts as success.
                if (mem_ready) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    stall_d = 1'b0;
                    done_d  = 1'b1;
                    dm_d    = mem_we ? 32'h0 : ld_data;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    stall_d = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    dm_d    = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                stall_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            stall     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            dm_rdata  <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_be    <= be_d;
            mem_wdata <= wdata_d;
            stall     <= stall_d;
            done      <= done_d;
            err       <= err_d;
            dm_rdata  <= dm_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] dm_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic st,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd);
        req_valid  = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we, stall, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {mem_req, mem_we, stall, done, err});
        end
        checks++;
        if ({mem_be, mem_addr, mem_wdata, dm_rdata} !== 100'h0) begin
            errors++;
            $display("FAIL reset_data: be=%h addr=%h wd=%h dm=%h want 0",
                     mem_be, mem_addr, mem_wdata, dm_rdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        present(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({mem_req, stall, mem_we, done, mem_be, mem_addr} !==
            {4'b1100, 4'hF, 32'h100}) begin
            errors++;
            $display("FAIL lw_issue: req=%b stall=%b we=%b done=%b be=%h addr=%h want 1 1 0 0 f 100",
                     mem_req, stall, mem_we, done, mem_be, mem_addr);
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({done, err, mem_req, stall} !== 4'b1000 || dm_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_done: done=%b err=%b req=%b stall=%b dm=%h want 1 0 0 0 deadbeef",
                     done, err, mem_req, stall, dm_rdata);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL lw_pulse: done=%b want 0", done);
        end
    endtask

    task automatic test_load_lanes();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] as  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] rds [4] = '{32'h80FF0011, 32'h80FF0011,
                                 32'h80011234, 32'h80011234};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080,
                                 32'hFFFF8001, 32'h00008001};
        for (int i = 0; i < 4; i++) begin
            present(1'b1, 1'b0, f3s[i], as[i], 32'h0);
            mem_ready = 1'b1;
            mem_rdata = rds[i];
            tick();
            req_valid = 1'b0;
            tick();
            mem_ready = 1'b0;
            checks++;
            if (done !== 1'b1 || err !== 1'b0 || dm_rdata !== exp[i]) begin
                errors++;
                $display("FAIL load_lane%0d: done=%b err=%b dm=%h want 1 0 %h",
                         i, done, err, dm_rdata, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int n;
        present(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        mem_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL timeout_len: busy=%0d want 16", n);
        end
        checks++;
        if ({done, err, mem_req, stall} !== 4'b1100 || dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_resp: done=%b err=%b req=%b stall=%b dm=%h want 1 1 0 0 0",
                     done, err, mem_req, stall, dm_rdata);
        end
        tick();
    endtask

    task automatic test_ready_at_timeout();
        int n;
        present(1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
        mem_ready = 1'b0;
        mem_rdata = 32'h5A5A5A5A;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (mem_req === 1'b1 && n < 40) begin
            mem_ready = (n == 16);
            n++;
            tick();
        end
        mem_ready = 1'b0;
        checks++;
        if ({done, err} !== 2'b10 || dm_rdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL ready_at_timeout: done=%b err=%b dm=%h want 1 0 5a5a5a5a",
                     done, err, dm_rdata);
        end
        tick();
    endtask

    task automatic test_store_sb();
        int scnt;
        present(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB);
        mem_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({mem_req, mem_we, mem_be} !== 6'b110010 ||
            mem_wdata !== 32'hABABABAB || mem_addr !== 32'h200) begin
            errors++;
            $display("FAIL sb_issue: req=%b we=%b be=%b wd=%h addr=%h want 1 1 0010 abababab 200",
                     mem_req, mem_we, mem_be, mem_wdata, mem_addr);
        end
        scnt = 0;
        for (int i = 1; i <= 5; i++) begin
            if (stall === 1'b1) scnt++;
            if (i == 4) begin
                checks++;
                if (mem_be !== 4'b0010 || mem_wdata !== 32'hABABABAB) begin
                    errors++;
                    $display("FAIL sb_hold: be=%b wd=%h want 0010 abababab",
                             mem_be, mem_wdata);
                end
            end
            mem_ready = (i == 5);
            tick();
        end
        mem_ready = 1'b0;
        checks++;
        if (scnt !== 5) begin
            errors++;
            $display("FAIL sb_stall: cycles=%0d want 5", scnt);
        end
        checks++;
        if ({done, err, stall} !== 3'b100 || dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL sb_done: done=%b err=%b stall=%b dm=%h want 1 0 0 0",
                     done, err, stall, dm_rdata);
        end
        tick();
    endtask

    task automatic test_store_hw();
        present(1'b0, 1'b1, 3'b001, 32'h206, 32'h1234CDEF);
        mem_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if (mem_be !== 4'b1100 || mem_wdata !== 32'hCDEFCDEF || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL sh_issue: be=%b wd=%h we=%b want 1100 cdefcdef 1",
                     mem_be, mem_wdata, mem_we);
        end
        tick();
        tick();
        present(1'b0, 1'b1, 3'b010, 32'h208, 32'h11223344);
        tick();
        req_valid = 1'b0;
        checks++;
        if (mem_be !== 4'b1111 || mem_wdata !== 32'h11223344 || mem_addr !== 32'h208) begin
            errors++;
            $display("FAIL sw_issue: be=%b wd=%h addr=%h want 1111 11223344 208",
                     mem_be, mem_wdata, mem_addr);
        end
        tick();
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        logic        lds [3] = '{1'b1, 1'b0, 1'b1};
        logic        sts [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s [3] = '{3'b010, 3'b100, 3'b000};
        logic [31:0] as  [3] = '{32'h102, 32'h200, 32'h200};
        for (int i = 0; i < 3; i++) begin
            present(lds[i], sts[i], f3s[i], as[i], 32'h0);
            mem_ready = 1'b1;
            tick();
            req_valid = 1'b0;
            mem_ready = 1'b0;
            checks++;
            if ({mem_req, stall, done, err} !== 4'b0011) begin
                errors++;
                $display("FAIL illegal%0d: req=%b stall=%b done=%b err=%b want 0 0 1 1",
                         i, mem_req, stall, done, err);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        present(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        mem_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({mem_req, stall, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid: req=%b stall=%b done=%b want 0 0 0",
                     mem_req, stall, done);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({mem_req, done, err} !== 3'b000 || dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL late_ready: req=%b done=%b err=%b dm=%h want 0 0 0 0",
                     mem_req, done, err, dm_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first  = -1;
        second = -1;
        present(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (done === 1'b1 && first < 0) first = e;
            else if (done === 1'b1 && second < 0) second = e;
        end
        req_valid = 1'b0;
        mem_ready = 1'b0;
        checks++;
        if (first !== 2 || second !== 5) begin
            errors++;
            $display("FAIL back_to_back: done edges %0d,%0d want 2,5",
                     first, second);
        end
        checks++;
        if (dm_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL b2b_data: dm=%h want cafef00d", dm_rdata);
        end
        tick();
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        test_reset();
        test_lw();
        test_load_lanes();
        test_timeout();
        test_ready_at_timeout();
        test_store_sb();
        test_store_hw();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
